// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM.
// States 10/11 exist only when MULTI_CYCLE_CTRL_ADDI_EN is defined.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StRExec    = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9
`ifdef MULTI_CYCLE_CTRL_ADDI_EN
    , StAddiExec = 4'd10,
    StAddiWb   = 4'd11
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multi_cycle_ctrl.sv
// Moore control FSM for the multi-cycle MIPS datapath.
// Define MULTI_CYCLE_CTRL_ADDI_EN to add the addi execute/writeback path.
module multi_cycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OPW = 6,
  parameter int unsigned SW  = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic [1:0]     alu_op,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     pc_source,
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic           ior_d,
  output logic           mem_read,
  output logic           mem_write,
  output logic           ir_write,
  output logic           mem_to_reg,
  output logic           reg_dst,
  output logic           reg_write,
  output logic           illegal_op,
  output logic [SW-1:0]  state
);

  state_e r_state;
  state_e w_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StFetch;
    else       r_state <= w_next;
  end

  assign state = SW'(r_state);

  always_comb begin
    w_next        = StFetch;
    alu_op        = ALUOP_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    pc_source     = PCSRC_ALU;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ior_d         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    illegal_op    = 1'b0;
    case (r_state)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        // Reset behaves as FETCH with the handshake held off.
        if (mem_ready && !reset) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
        w_next = mem_ready ? StDecode : StFetch;
      end
      StDecode: begin
        alu_src_b = SRCB_IMM_SH;
        if (opcode == OPW'(OP_RTYPE))                                w_next = StRExec;
        else if (opcode == OPW'(OP_LW) || opcode == OPW'(OP_SW))     w_next = StMemAddr;
        else if (opcode == OPW'(OP_BEQ))                             w_next = StBranch;
        else if (opcode == OPW'(OP_J))                               w_next = StJump;
`ifdef MULTI_CYCLE_CTRL_ADDI_EN
        else if (opcode == OPW'(OP_ADDI))                            w_next = StAddiExec;
`endif
        else                                                         illegal_op = 1'b1;
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (opcode == OPW'(OP_LW))      w_next = StMemRead;
        else if (opcode == OPW'(OP_SW)) w_next = StMemWrite;
      end
      StMemRead: begin
        mem_read = 1'b1;
        ior_d    = 1'b1;
        w_next   = mem_ready ? StMemWb : StMemRead;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWrite: begin
        mem_write = 1'b1;
        ior_d     = 1'b1;
        w_next    = mem_ready ? StFetch : StMemWrite;
      end
      StRExec: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        w_next    = StRWb;
      end
      StRWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
`ifdef MULTI_CYCLE_CTRL_ADDI_EN
      StAddiExec: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_next    = StAddiWb;
      end
      StAddiWb: begin
        reg_write = 1'b1;
      end
`endif
      default: w_next = StFetch;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: instruction-level model plus directed
// literal checks, then randomized opcodes and memory handshake stalls.
module tb_multi_cycle_ctrl;

`ifdef MULTI_CYCLE_CTRL_ADDI_EN
  localparam bit AddiEn = 1'b1;
`else
  localparam bit AddiEn = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] pc_src;
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, ill;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic [1:0] alu_op, alu_src_b, pc_source;
  logic       alu_src_a, pc_write, pc_write_cond, ior_d, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, illegal_op;
  logic [3:0] state;

  multi_cycle_ctrl #(.OPW(6), .SW(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .ior_d(ior_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  int   m_state = 0;
  int   m_q[$];
  ctl_t act;
  ctl_t key[16];

  assign act = {state, alu_op, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond,
                ior_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
                illegal_op};

  function automatic bit legal(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h23) || (op == 6'h2b) || (op == 6'h04) ||
           (op == 6'h02) || (AddiEn && op == 6'h08);
  endfunction

  // Expected control word for each state, straight from the state table.
  function automatic ctl_t expect_ctl(input int s, input logic [5:0] op, input logic mr,
                                      input logic rst);
    ctl_t c;
    c = '0;
    c.st = 4'(s);
    case (s)
      0:  begin c.mrd = 1; c.src_b = 2'b01; c.irw = mr & ~rst; c.pcw = mr & ~rst; end
      1:  begin c.src_b = 2'b11; c.ill = !legal(op); end
      2:  begin c.src_a = 1; c.src_b = 2'b10; end
      3:  begin c.mrd = 1; c.iord = 1; end
      4:  begin c.rw = 1; c.m2r = 1; end
      5:  begin c.mwr = 1; c.iord = 1; end
      6:  begin c.src_a = 1; c.alu_op = 2'b10; end
      7:  begin c.rw = 1; c.rdst = 1; end
      8:  begin c.src_a = 1; c.alu_op = 2'b01; c.pcwc = 1; c.pc_src = 2'b01; end
      9:  begin c.pcw = 1; c.pc_src = 2'b10; end
      10: begin c.src_a = 1; c.src_b = 2'b10; end
      11: begin c.rw = 1; end
      default: ;
    endcase
    return c;
  endfunction

  // Model advance: after DECODE, an instruction is just a list of remaining states.
  task automatic adv(input logic [5:0] op, input logic mr);
    if (m_state == 0) begin
      if (mr) m_state = 1;
    end else if ((m_state == 3 || m_state == 5) && !mr) begin
      m_state = m_state;
    end else begin
      if (m_state == 1) begin
        m_q.delete();
        case (op)
          6'h00: begin m_q.push_back(6); m_q.push_back(7); end
          6'h23: begin m_q.push_back(2); m_q.push_back(3); m_q.push_back(4); end
          6'h2b: begin m_q.push_back(2); m_q.push_back(5); end
          6'h04: m_q.push_back(8);
          6'h02: m_q.push_back(9);
          6'h08: if (AddiEn) begin m_q.push_back(10); m_q.push_back(11); end
          default: ;
        endcase
      end
      m_state = (m_q.size() != 0) ? m_q.pop_front() : 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  always @(negedge clk) begin
    ctl_t e;
    e = expect_ctl(m_state, opcode, mem_ready, reset);
    n_chk++;
    if (act !== e) begin
      n_err++;
      $display("FAIL cycle_ctl t=%0t: got %h expected %h", $time, act, e);
    end
  end

  // One clock: drive at posedge+1, observe at negedge, advance model at posedge.
  task automatic cycle(input logic mr, input logic [5:0] op);
    mem_ready = mr;
    opcode    = op;
    @(negedge clk);
    key[state] = act;
    @(posedge clk);
    adv(op, mr);
    #1;
  endtask

  task automatic run_dir(input string name, input logic [5:0] op, input int stalls,
                         input int e_cyc, input logic [31:0] e_seq, input int e_rw,
                         input int e_mw, input int e_ill);
    int cyc = 0, rw = 0, mw = 0, ill = 0, left = stalls;
    logic [31:0] seq = '0;
    logic mr;
    for (int i = 0; i < 30; i++) begin
      mr = 1'b1;
      if ((m_state == 3 || m_state == 5) && left > 0) begin
        mr = 1'b0;
        left--;
      end
      mem_ready = mr;
      opcode    = op;
      @(negedge clk);
      key[state] = act;
      seq = {seq[27:0], state};
      cyc++;
      rw  += int'(reg_write);
      mw  += int'(mem_write);
      ill += int'(illegal_op);
      @(posedge clk);
      adv(op, mr);
      #1;
      if (m_state == 0) break;
    end
    chk({name, "_cycles"}, 32'(cyc), 32'(e_cyc));
    chk({name, "_states"}, seq, e_seq);
    chk({name, "_reg_write"}, 32'(rw), 32'(e_rw));
    chk({name, "_mem_write"}, 32'(mw), 32'(e_mw));
    chk({name, "_illegal"}, 32'(ill), 32'(e_ill));
  endtask

  initial begin
    logic [5:0] picks[9];
    logic [5:0] cur_op;
    logic [5:0] drv;
    for (int i = 0; i < 16; i++) key[i] = '0;
    reset = 1'b1;
    mem_ready = 1'b0;
    opcode = 6'h00;
    #2;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_mem_read", 32'(mem_read), 32'd1);
    chk("reset_src_b", 32'(alu_src_b), 32'd1);
    chk("reset_ir_write", 32'(ir_write), 32'd0);
    #5 reset = 1'b0;
    @(posedge clk);
    adv(6'h00, 1'b0);
    #1;

    run_dir("lw",   6'h23, 0, 5, 32'h0000_1234, 1, 0, 0);
    chk("lw_wb_mdr", 32'({key[4].rw, key[4].m2r}), 32'b11);
    run_dir("sw",   6'h2b, 2, 6, 32'h0001_2555, 0, 3, 0);
    run_dir("rtyp", 6'h00, 0, 4, 32'h0000_0167, 1, 0, 0);
    chk("rtyp_aluop", 32'(key[6].alu_op), 32'b10);
    chk("rtyp_wb", 32'({key[7].rw, key[7].rdst}), 32'b11);
    run_dir("beq",  6'h04, 0, 3, 32'h0000_0018, 0, 0, 0);
    chk("beq_ctl", 32'({key[8].alu_op, key[8].pcwc, key[8].pc_src}), 32'b01_1_01);
    run_dir("j",    6'h02, 0, 3, 32'h0000_0019, 0, 0, 0);
    chk("j_ctl", 32'({key[9].pcw, key[9].pc_src}), 32'b1_10);
    run_dir("ill",  6'h3f, 0, 2, 32'h0000_0001, 0, 0, 1);
    run_dir("addi", 6'h08, 0, AddiEn ? 4 : 2, AddiEn ? 32'h0000_01ab : 32'h0000_0001,
            AddiEn ? 1 : 0, 0, AddiEn ? 0 : 1);
    chk("addi_src_b", 32'(key[10].src_b), AddiEn ? 32'd2 : 32'd0);

    // Asynchronous reset in the middle of a stalled load.
    cycle(1'b1, 6'h23);
    cycle(1'b1, 6'h23);
    cycle(1'b1, 6'h23);
    chk("pre_reset_state", 32'(state), 32'd3);
    mem_ready = 1'b0;
    #2 reset = 1'b1;
    m_state = 0;
    m_q.delete();
    #1;
    chk("async_reset_state", 32'(state), 32'd0);
    chk("async_reset_mem_read", 32'(mem_read), 32'd1);
    chk("async_reset_reg_write", 32'(reg_write), 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    adv(6'h23, 1'b0);
    #1;
    cycle(1'b1, 6'h3f);
    chk("post_reset_fetch", 32'(state), 32'd1);

    picks = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08, 6'h3f, 6'h23, 6'h11};
    cur_op = 6'h3f;
    for (int i = 0; i < 2000; i++) begin
      if (m_state == 0) begin
        cur_op = picks[$urandom_range(0, 8)];
        if ($urandom_range(0, 9) == 0) cur_op = 6'($urandom);
      end
      drv = (m_state <= 2) ? cur_op : 6'($urandom);
      cycle($urandom_range(0, 3) != 0, drv);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback.
- Drives the 2-bit aluOp consumed by the ALU control decoder, plus all datapath mux selects and write enables.
- Stalls on a memory ready handshake; sits beside the datapath in the CPU top level.

Parameters:
- OPW, 6, opcode width.
- SW, 4, state register width.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; forces state FETCH
- opcode  input  6  instr[31:26] from the instruction register
- mem_ready  input  1  memory has completed the current read or write this cycle
- alu_op  output  2  00 add, 01 sub (beq), 10 use funct
- alu_src_a  output  1  0 = PC, 1 = register A
- alu_src_b  output  2  00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load when ALU zero
- ior_d  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  register writeback source: 1 = MDR
- reg_dst  output  1  1 = rd, 0 = rt
- reg_write  output  1  register file write
- illegal_op  output  1  one-cycle pulse on an unsupported opcode
- state  output  SW  current state, for debug

Behaviour:
- Moore FSM. Outputs decode combinationally from the state; mem_ready gating is the only input term.
- Any signal not listed for a state is 0.
- Reset (asynchronous, active-high, any time, including mid-instruction or mid-stall): state = FETCH.
  - During reset, outputs equal the FETCH outputs with mem_ready = 0: mem_read = 1, alu_src_b = 01; all others 0.
- FETCH(0): mem_read = 1, ior_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write and pc_write are asserted only while mem_ready = 1.
  - Advance to DECODE when mem_ready = 1, else hold.
- DECODE(1): alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target into ALUOut). Next state by opcode:
  - 000000 -> R_EXEC
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - anything else -> FETCH, with illegal_op = 1 for this cycle.
- MEM_ADDR(2): alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next: lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ(3): mem_read = 1, ior_d = 1. Hold until mem_ready, then MEM_WB.
- MEM_WB(4): reg_write = 1, mem_to_reg = 1, reg_dst = 0. Next: FETCH.
- MEM_WRITE(5): mem_write = 1, ior_d = 1. Hold until mem_ready, then FETCH.
- R_EXEC(6): alu_src_a = 1, alu_src_b = 00, alu_op = 10. Next: R_WB.
- R_WB(7): reg_write = 1, reg_dst = 1, mem_to_reg = 0. Next: FETCH.
- BRANCH(8): alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01. Next: FETCH.
- JUMP(9): pc_write = 1, pc_source = 10. Next: FETCH.
- Unused state codes go to FETCH on the next clock.
- Cycle counts with mem_ready always 1:
  - lw 5, sw 4, R-type 4, beq 3, j 3.
  - Each cycle mem_ready is low in a memory state adds one cycle.
- opcode is sampled only in DECODE and MEM_ADDR; changes in other states are ignored.

Optional Feature:
- Macro: MULTI_CYCLE_CTRL_ADDI_EN.
- When defined, opcode 001000 (addi) decodes in DECODE to ADDI_EXEC and does not raise illegal_op.
  - ADDI_EXEC(10): alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next: ADDI_WB.
  - ADDI_WB(11): reg_write = 1, reg_dst = 0, mem_to_reg = 0. Next: FETCH.
- When undefined, 001000 is illegal: FETCH next, illegal_op pulses, and states 10/11 do not exist.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state code constants;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - alu_op encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT);
  - alu_src_b and pc_source select encodings.
- No sub-module; the next-state logic and output decode are two processes in one module.

Test Plan:
- Reset asserted mid-MEM_READ while mem_ready = 0 -> state = 0 immediately (asynchronously), mem_read = 1, reg_write = 0; first FETCH completes after release.
- lw (100011), mem_ready held 1 -> states 0,1,2,3,4,0; reg_write = 1 with mem_to_reg = 1 only in state 4; total 5 cycles.
- sw (101011), mem_ready low for 2 cycles in MEM_WRITE -> mem_write held 3 cycles, no reg_write, back to FETCH after 6 cycles.
- R-type (000000) -> alu_op = 10 in R_EXEC, reg_dst = 1 with reg_write = 1 in R_WB; beq (000100) -> alu_op = 01, pc_write_cond = 1, pc_source = 01 in state 8.
- j (000010) -> pc_write = 1, pc_source = 10 in state 9.
- opcode 111111 -> illegal_op pulses for exactly 1 cycle in DECODE, then FETCH.
- opcode 001000:
  - with MULTI_CYCLE_CTRL_ADDI_EN -> states 0,1,10,11,0, with alu_src_b = 10 in state 10;
  - without it -> illegal_op pulse.
